// File: rtl/mips_datapath_alu_muldiv.sv
// Iterative HI/LO multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
module mips_datapath_alu_muldiv #(
    parameter int DATA_W = 32
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_data1,
    input  logic [DATA_W-1:0] i_data2,
    input  logic              i_flush,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo,
    output logic              o_divZero
);

    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [2*DATA_W-1:0] r_acc;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_raw;
    logic                r_is_div;
    logic                r_neg_lo;
    logic                r_neg_hi;
    logic                r_div0;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic                r_done;
    logic                r_divZero;

    logic              w_accept;
    logic              w_md;
    logic              w_mthi;
    logic              w_mtlo;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [DATA_W-1:0] w_abs1;
    logic [DATA_W-1:0] w_abs2;

    assign w_accept = (r_state == S_IDLE) && i_start && !i_flush;
    assign w_md     = w_accept && !i_op[2];
    assign w_mthi   = w_accept && (i_op == 3'd4);
    assign w_mtlo   = w_accept && (i_op == 3'd5);
    // Even op codes (MULT, DIV) are the signed forms
    assign w_a_neg  = !i_op[0] && i_data1[DATA_W-1];
    assign w_b_neg  = !i_op[0] && i_data2[DATA_W-1];
    assign w_abs1   = w_a_neg ? -i_data1 : i_data1;
    assign w_abs2   = w_b_neg ? -i_data2 : i_data2;

    // Multiply step: conditional add into the high half, then shift right
    logic [DATA_W:0]     w_sum;
    logic [2*DATA_W-1:0] w_mul_nxt;

    assign w_sum     = {1'b0, r_acc[2*DATA_W-1:DATA_W]}
                     + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_nxt = {w_sum, r_acc[DATA_W-1:1]};

    // Divide step: remainder in the high half, quotient shifts into the low
    logic [DATA_W:0]     w_rsh;
    logic                w_ge;
    logic [DATA_W-1:0]   w_rem_sub;
    logic [2*DATA_W-1:0] w_div_nxt;

    assign w_rsh     = {r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1]};
    assign w_ge      = w_rsh >= {1'b0, r_b};
    assign w_rem_sub = w_rsh[DATA_W-1:0] - r_b;
    assign w_div_nxt = w_ge
        ? {w_rem_sub, r_acc[DATA_W-2:0], 1'b1}
        : {w_rsh[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0};

    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_fix_hi;
    logic [DATA_W-1:0]   w_fix_lo;

    assign w_prod = r_neg_lo ? -r_acc : r_acc;

    always_comb begin
        w_fix_hi = w_prod[2*DATA_W-1:DATA_W];
        w_fix_lo = w_prod[DATA_W-1:0];
        if (r_is_div) begin
            if (r_div0) begin
                w_fix_hi = r_raw;
                w_fix_lo = '1;
            end else begin
                w_fix_lo = r_neg_lo ? -r_acc[DATA_W-1:0]
                                    : r_acc[DATA_W-1:0];
                w_fix_hi = r_neg_hi ? -r_acc[2*DATA_W-1:DATA_W]
                                    : r_acc[2*DATA_W-1:DATA_W];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_md) w_state_nxt = S_RUN;
            S_RUN: begin
                if (i_flush)
                    w_state_nxt = S_IDLE;
                else if (r_cnt == CW'(1))
                    w_state_nxt = S_FIX;
            end
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_b       <= '0;
            r_raw     <= '0;
            r_is_div  <= 1'b0;
            r_neg_lo  <= 1'b0;
            r_neg_hi  <= 1'b0;
            r_div0    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_divZero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_md) begin
                r_is_div  <= i_op[1];
                r_neg_lo  <= w_a_neg ^ w_b_neg;
                r_neg_hi  <= w_a_neg;
                r_raw     <= i_data1;
                r_div0    <= i_op[1] && (i_data2 == '0);
                r_divZero <= 1'b0;
                r_cnt     <= CW'(DATA_W);
                r_b       <= i_op[1] ? w_abs2 : w_abs1;
                r_acc     <= {{DATA_W{1'b0}},
                              (i_op[1] ? w_abs1 : w_abs2)};
            end
            if (w_mthi) r_hi <= i_data1;
            if (w_mtlo) r_lo <= i_data1;
            if (r_state == S_RUN) begin
                r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
                r_cnt <= r_cnt - CW'(1);
            end
            if (r_state == S_FIX && !i_flush) begin
                r_hi      <= w_fix_hi;
                r_lo      <= w_fix_lo;
                r_done    <= 1'b1;
                r_divZero <= r_div0;
            end
        end
    end

    assign o_busy    = (r_state != S_IDLE);
    assign o_done    = r_done;
    assign o_hi      = r_hi;
    assign o_lo      = r_lo;
    assign o_divZero = r_divZero;

endmodule
